// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and defaults for the IF/MEM SRAM arbiter
package mem_port_arbiter_pkg;
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_CNT_W  = 4;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_DONE} arb_state_t;
  typedef enum logic {OWNER_IF, OWNER_D} owner_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: pipeline request ports and SRAM bus seen by the arbiter
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              d_rd;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              freeze;
  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  modport slave (
    input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, sram_rdata,
    output if_rdata, if_ready, d_rdata, d_ready, freeze, sram_en, sram_we, sram_addr, sram_wdata
  );
  modport master (
    output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, sram_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready, freeze, sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency SRAM between IF and MEM, data first, freezing the pipeline until all are served
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int DATA_W  = ARB_DATA_W,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_port_arbiter: LATENCY must be within 1..15");
  end
  arb_state_t           state, state_nx;
  owner_t               owner;
  logic [ARB_CNT_W-1:0] cnt;
  logic                 d_served, i_served;
  logic                 d_need, i_need, d_pend, i_pend;
  logic                 grant, last, done;
  logic [ADDR_W-1:0]    addr_sel;
  logic [DATA_W-1:0]    rdata;
  assign d_need        = bus.d_rd | bus.d_wr;
  assign i_need        = bus.if_req;
  assign d_pend        = d_need & ~d_served;
  assign i_pend        = i_need & ~i_served;
  assign bus.freeze    = d_pend | i_pend;
  assign bus.if_ready  = i_served;
  assign bus.d_ready   = d_served;
  assign grant         = (state == ARB_IDLE) && bus.freeze;
  assign last          = (state == ARB_ACCESS) && (cnt == '0);
  assign done          = state == ARB_DONE;
  assign addr_sel      = d_pend ? bus.d_addr : bus.if_addr;
  assign rdata         = bus.sram_rdata;
  // next state: grant from IDLE, count down in ACCESS, one DONE cycle to post the served flag
  always_comb begin
    state_nx = state;
    state_nx = (state == ARB_IDLE) ? (bus.freeze ? ARB_ACCESS : ARB_IDLE) :
               (state == ARB_ACCESS) ? (cnt == '0 ? ARB_DONE : ARB_ACCESS) : ARB_IDLE;
  end
  // state, SRAM strobes, captured read data and served flags (flags clear whenever the pipeline advances)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ARB_IDLE;
      owner          <= OWNER_IF;
      cnt            <= '0;
      d_served       <= 1'b0;
      i_served       <= 1'b0;
      bus.sram_en    <= 1'b0;
      bus.sram_we    <= 1'b0;
      bus.sram_addr  <= '0;
      bus.sram_wdata <= '0;
      bus.if_rdata   <= '0;
      bus.d_rdata    <= '0;
    end else begin
      state    <= state_nx;
      d_served <= (done && owner == OWNER_D && d_need) || (d_served && bus.freeze);
      i_served <= (done && owner == OWNER_IF && i_need) || (i_served && bus.freeze);
      if (grant) begin
        owner          <= d_pend ? OWNER_D : OWNER_IF;
        bus.sram_en    <= 1'b1;
        bus.sram_we    <= d_pend & bus.d_wr;
        bus.sram_addr  <= addr_sel;
        bus.sram_wdata <= bus.d_wdata;
        cnt            <= ARB_CNT_W'(LATENCY - 1);
      end
      if (state == ARB_ACCESS && !last) cnt <= cnt - 1'b1;
      if (last) begin
        bus.sram_en <= 1'b0;
        bus.sram_we <= 1'b0;
      end
      if (last && !bus.sram_we && owner == OWNER_D) bus.d_rdata <= rdata;
      if (last && !bus.sram_we && owner == OWNER_IF) bus.if_rdata <= rdata;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of the arbiter at LATENCY 2, 3 and 1
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_rd, d_wr;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        ld;
  logic [5:0]  ld_a;
  logic [31:0] ld_d;
  logic [2:0]  fz, en, we, ir, dr;
  logic [31:0] ird [3];
  logic [31:0] drd [3];
  logic [31:0] sa [3];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int L = g == 0 ? 2 : g == 1 ? 3 : 1;
    mem_port_arbiter_if bus ();
    logic [31:0] mem [0:63];
    assign bus.if_req     = if_req;
    assign bus.if_addr    = if_addr;
    assign bus.d_rd       = d_rd;
    assign bus.d_wr       = d_wr;
    assign bus.d_addr     = d_addr;
    assign bus.d_wdata    = d_wdata;
    assign bus.sram_rdata = mem[bus.sram_addr[7:2]];
    always @(posedge clk) begin
      if (ld) mem[ld_a] <= ld_d;
      else if (bus.sram_en && bus.sram_we) mem[bus.sram_addr[7:2]] <= bus.sram_wdata;
    end
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(L)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    assign fz[g]  = bus.freeze;
    assign en[g]  = bus.sram_en;
    assign we[g]  = bus.sram_we;
    assign ir[g]  = bus.if_ready;
    assign dr[g]  = bus.d_ready;
    assign ird[g] = bus.if_rdata;
    assign drd[g] = bus.d_rdata;
    assign sa[g]  = bus.sram_addr;
  end
  task automatic reset_all;
    rst_n = 1'b0;
    if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    ld = 1'b0; ld_a = '0; ld_d = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic load(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ld = 1'b1; ld_a = a[7:2]; ld_d = d;
    @(negedge clk);
    ld = 1'b0;
  endtask
  task automatic advance;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int k, output int frz, output int pulses, output int wes, output logic [31:0] first);
    logic prev;
    frz = 0; pulses = 0; wes = 0; first = '0;
    #1;
    prev = en[k];
    while (fz[k] && frz < 40) begin
      frz++;
      @(posedge clk);
      #1;
      if (en[k] && !prev) begin
        pulses++;
        if (pulses == 1) first = sa[k];
      end
      if (we[k]) wes++;
      prev = en[k];
    end
    checks++;
    if (fz[k] !== 1'b0) begin
      errors++;
      $display("FAIL freeze_timeout inst %0d: freeze=%b required 0", k, fz[k]);
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++; if (en !== 3'b000) begin errors++; $display("FAIL reset_sram_en got %b required 000", en); end
    checks++; if (we !== 3'b000) begin errors++; $display("FAIL reset_sram_we got %b required 000", we); end
    checks++; if (ir !== 3'b000) begin errors++; $display("FAIL reset_if_ready got %b required 000", ir); end
    checks++; if (dr !== 3'b000) begin errors++; $display("FAIL reset_d_ready got %b required 000", dr); end
    checks++; if (ird[0] !== 32'h0) begin errors++; $display("FAIL reset_if_rdata got %h required 0", ird[0]); end
    checks++; if (drd[0] !== 32'h0) begin errors++; $display("FAIL reset_d_rdata got %h required 0", drd[0]); end
    checks++; if (sa[0] !== 32'h0) begin errors++; $display("FAIL reset_sram_addr got %h required 0", sa[0]); end
    reset_all;
    repeat (3) @(negedge clk);
    checks++; if (fz !== 3'b000) begin errors++; $display("FAIL idle_freeze got %b required 000", fz); end
    checks++; if (en !== 3'b000) begin errors++; $display("FAIL idle_sram_en got %b required 000", en); end
  endtask
  task automatic test_single_fetch;
    int frz, pulses, wes;
    logic [31:0] first;
    reset_all;
    load(32'h10, 32'h0000A5A5);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    run(0, frz, pulses, wes, first);
    checks++; if (frz != 4) begin errors++; $display("FAIL fetch_freeze_cycles got %0d required 4", frz); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL fetch_en_pulses got %0d required 1", pulses); end
    checks++; if (first !== 32'h10) begin errors++; $display("FAIL fetch_sram_addr got %h required 10", first); end
    checks++; if (ir[0] !== 1'b1) begin errors++; $display("FAIL fetch_if_ready got %b required 1", ir[0]); end
    checks++; if (ird[0] !== 32'h0000A5A5) begin errors++; $display("FAIL fetch_if_rdata got %h required 0000a5a5", ird[0]); end
    advance;
    if_req = 1'b0;
    checks++; if (ir[0] !== 1'b0) begin errors++; $display("FAIL fetch_ready_cleared got %b required 0", ir[0]); end
    checks++; if (ird[0] !== 32'h0000A5A5) begin errors++; $display("FAIL fetch_rdata_held got %h required 0000a5a5", ird[0]); end
  endtask
  task automatic test_simultaneous;
    int frz, pulses, wes;
    logic [31:0] first;
    reset_all;
    load(32'h20, 32'h1111);
    load(32'h10, 32'h2222);
    @(negedge clk);
    d_rd = 1'b1; d_addr = 32'h20; if_req = 1'b1; if_addr = 32'h10;
    run(0, frz, pulses, wes, first);
    checks++; if (frz != 8) begin errors++; $display("FAIL both_freeze_cycles got %0d required 8", frz); end
    checks++; if (pulses != 2) begin errors++; $display("FAIL both_en_pulses got %0d required 2", pulses); end
    checks++; if (first !== 32'h20) begin errors++; $display("FAIL both_first_addr got %h required 20", first); end
    checks++; if (wes != 0) begin errors++; $display("FAIL both_we_cycles got %0d required 0", wes); end
    checks++; if (drd[0] !== 32'h1111) begin errors++; $display("FAIL both_d_rdata got %h required 1111", drd[0]); end
    checks++; if (ird[0] !== 32'h2222) begin errors++; $display("FAIL both_if_rdata got %h required 2222", ird[0]); end
    checks++; if ({dr[0], ir[0]} !== 2'b11) begin errors++; $display("FAIL both_ready got %b required 11", {dr[0], ir[0]}); end
    advance;
    d_rd = 1'b0; if_req = 1'b0;
  endtask
  task automatic test_write_read;
    int frz, pulses, wes;
    logic [31:0] first;
    reset_all;
    @(negedge clk);
    d_wr = 1'b1; d_addr = 32'h30; d_wdata = 32'hDEAD;
    run(0, frz, pulses, wes, first);
    checks++; if (wes != 2) begin errors++; $display("FAIL wr_we_cycles got %0d required 2", wes); end
    checks++; if (dr[0] !== 1'b1) begin errors++; $display("FAIL wr_d_ready got %b required 1", dr[0]); end
    checks++; if (drd[0] !== 32'h0) begin errors++; $display("FAIL wr_d_rdata_untouched got %h required 0", drd[0]); end
    advance;
    d_wr = 1'b0; d_rd = 1'b1; d_wdata = 32'h0;
    run(0, frz, pulses, wes, first);
    checks++; if (wes != 0) begin errors++; $display("FAIL rd_we_cycles got %0d required 0", wes); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL rd_en_pulses got %0d required 1", pulses); end
    checks++; if (drd[0] !== 32'hDEAD) begin errors++; $display("FAIL rd_d_rdata got %h required dead", drd[0]); end
    advance;
    d_rd = 1'b0;
  endtask
  task automatic test_reset_mid_access;
    int frz, pulses, wes;
    logic [31:0] first;
    reset_all;
    load(32'h40, 32'hBEEF);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40;
    advance;
    checks++; if (en[0] !== 1'b1) begin errors++; $display("FAIL mid_en_before got %b required 1", en[0]); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (en[0] !== 1'b0) begin errors++; $display("FAIL mid_en_async got %b required 0", en[0]); end
    checks++; if (sa[0] !== 32'h0) begin errors++; $display("FAIL mid_addr_async got %h required 0", sa[0]); end
    checks++; if (ir[0] !== 1'b0) begin errors++; $display("FAIL mid_ready_async got %b required 0", ir[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    run(0, frz, pulses, wes, first);
    checks++; if (frz != 4) begin errors++; $display("FAIL mid_after_freeze got %0d required 4", frz); end
    checks++; if (ird[0] !== 32'hBEEF) begin errors++; $display("FAIL mid_after_rdata got %h required beef", ird[0]); end
    advance;
    if_req = 1'b0;
  endtask
  task automatic test_flush;
    int frz, pulses, wes;
    logic [31:0] first;
    reset_all;
    load(32'h50, 32'h5555);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h50;
    advance;
    checks++; if (en[1] !== 1'b1) begin errors++; $display("FAIL flush_en_started got %b required 1", en[1]); end
    if_req = 1'b0;
    #1;
    checks++; if (fz[1] !== 1'b0) begin errors++; $display("FAIL flush_freeze got %b required 0", fz[1]); end
    repeat (6) @(negedge clk);
    checks++; if (ir[1] !== 1'b0) begin errors++; $display("FAIL flush_if_ready got %b required 0", ir[1]); end
    checks++; if (en[1] !== 1'b0) begin errors++; $display("FAIL flush_en_done got %b required 0", en[1]); end
    if_req = 1'b1; if_addr = 32'h50;
    run(1, frz, pulses, wes, first);
    checks++; if (frz != 5) begin errors++; $display("FAIL flush_next_freeze got %0d required 5", frz); end
    checks++; if (ird[1] !== 32'h5555) begin errors++; $display("FAIL flush_next_rdata got %h required 5555", ird[1]); end
    advance;
    if_req = 1'b0;
  endtask
  task automatic test_back_to_back;
    int frz, pulses, wes;
    logic [31:0] first;
    logic [31:0] exp_d [3];
    exp_d = '{32'h100, 32'h104, 32'h108};
    reset_all;
    for (int i = 0; i < 3; i++) load(32'(4 * i), exp_d[i]);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if_req = 1'b1; if_addr = 32'(4 * i);
      run(2, frz, pulses, wes, first);
      checks++; if (frz != 3) begin errors++; $display("FAIL b2b_freeze[%0d] got %0d required 3", i, frz); end
      checks++; if (pulses != 1) begin errors++; $display("FAIL b2b_en_pulses[%0d] got %0d required 1", i, pulses); end
      checks++; if (first !== 32'(4 * i)) begin errors++; $display("FAIL b2b_addr[%0d] got %h required %h", i, first, 4 * i); end
      checks++; if (ird[2] !== exp_d[i]) begin errors++; $display("FAIL b2b_rdata[%0d] got %h required %h", i, ird[2], exp_d[i]); end
      advance;
    end
    if_req = 1'b0;
  endtask
  initial begin
    test_reset;
    test_single_fetch;
    test_simultaneous;
    test_write_read;
    test_reset_mid_access;
    test_flush;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
